// File: rtl/rf_rename_ckpt.sv
// rf_rename_ckpt
//   Architectural register file with a rename (dependency) table and CKPT_NUM
//   snapshots of that table for single-cycle mispredict recovery.
//   Sits between the Dispatcher (queries sources, claims rd) and the RoB
//   (commits results, raises flush).
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                0 = hold all state
//   flush_signal          clear every dependency and checkpoint entry
//   commit_*              COMMIT_PORTS packed commit channels (higher = younger)
//   rs1/rs2 -> Qj/Vj,Qk/Vk  zero-latency source query
//   new_entry_*, occupied_rd  dispatch claim of rd
//   ckpt_en/ckpt_id       snapshot next-state table into a slot
//   recover_en/recover_id restore a slot into the dependency table
module rf_rename_ckpt #(
  parameter int RoB_WIDTH    = 3,
  parameter int REG_WIDTH    = 5,
  parameter int COMMIT_PORTS = 2,
  parameter int CKPT_WIDTH   = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              flush_signal,
  input  logic [COMMIT_PORTS-1:0]           commit_en,
  input  logic [REG_WIDTH*COMMIT_PORTS-1:0] commit_reg,
  input  logic [RoB_WIDTH*COMMIT_PORTS-1:0] commit_index,
  input  logic [32*COMMIT_PORTS-1:0]        commit_data,
  input  logic [REG_WIDTH-1:0]              rs1,
  input  logic [REG_WIDTH-1:0]              rs2,
  output logic [RoB_WIDTH:0]                Qj,
  output logic [RoB_WIDTH:0]                Qk,
  output logic [31:0]                       Vj,
  output logic [31:0]                       Vk,
  input  logic                              new_entry_en,
  input  logic [RoB_WIDTH-1:0]              new_entry_robEntry,
  input  logic [REG_WIDTH-1:0]              occupied_rd,
  input  logic                              ckpt_en,
  input  logic [CKPT_WIDTH-1:0]             ckpt_id,
  input  logic                              recover_en,
  input  logic [CKPT_WIDTH-1:0]             recover_id
);

  localparam int REG_SIZE = 1 << REG_WIDTH;
  localparam int CKPT_NUM = 1 << CKPT_WIDTH;
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  logic [31:0]        r_regs [REG_SIZE];
  logic [RoB_WIDTH:0] r_dep  [REG_SIZE];
  logic [RoB_WIDTH:0] r_ckpt [CKPT_NUM][REG_SIZE];

  logic [REG_WIDTH-1:0] w_creg   [COMMIT_PORTS];
  logic [RoB_WIDTH-1:0] w_cidx   [COMMIT_PORTS];
  logic [31:0]          w_cdata  [COMMIT_PORTS];
  logic                 w_cvalid [COMMIT_PORTS];

  logic [RoB_WIDTH:0] w_dep_clr  [REG_SIZE];
  logic [RoB_WIDTH:0] w_ckpt_clr [CKPT_NUM][REG_SIZE];
  logic [RoB_WIDTH:0] w_dep_next [REG_SIZE];

  logic [REG_WIDTH-1:0] w_rs [2];
  logic [RoB_WIDTH:0]   w_q  [2];
  logic [31:0]          w_v  [2];

  always_comb begin
    for (int p = 0; p < COMMIT_PORTS; p++) begin
      w_creg[p]   = commit_reg[p*REG_WIDTH +: REG_WIDTH];
      w_cidx[p]   = commit_index[p*RoB_WIDTH +: RoB_WIDTH];
      w_cdata[p]  = commit_data[p*32 +: 32];
      w_cvalid[p] = commit_en[p] && (w_creg[p] != '0);
    end
  end

  // A commit retires the producer only if the table still names that RoB
  // entry; a younger claim of the same rd must survive.
  always_comb begin
    for (int r = 0; r < REG_SIZE; r++) begin
      w_dep_clr[r] = r_dep[r];
      for (int c = 0; c < CKPT_NUM; c++) w_ckpt_clr[c][r] = r_ckpt[c][r];
      for (int p = 0; p < COMMIT_PORTS; p++) begin
        if (w_cvalid[p] && (w_creg[p] == REG_WIDTH'(r))) begin
          if (r_dep[r] == {1'b0, w_cidx[p]}) w_dep_clr[r] = NON_DEP;
          for (int c = 0; c < CKPT_NUM; c++)
            if (r_ckpt[c][r] == {1'b0, w_cidx[p]}) w_ckpt_clr[c][r] = NON_DEP;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < REG_SIZE; r++)
      w_dep_next[r] = recover_en ? w_ckpt_clr[recover_id][r] : w_dep_clr[r];
    if (!recover_en && new_entry_en && (occupied_rd != '0))
      w_dep_next[occupied_rd] = {1'b0, new_entry_robEntry};
    w_dep_next[0] = NON_DEP;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < REG_SIZE; r++) begin
        r_regs[r] <= '0;
        r_dep[r]  <= NON_DEP;
        for (int c = 0; c < CKPT_NUM; c++) r_ckpt[c][r] <= NON_DEP;
      end
    end else if (rdy_in) begin
      if (flush_signal) begin
        for (int r = 0; r < REG_SIZE; r++) begin
          r_dep[r] <= NON_DEP;
          for (int c = 0; c < CKPT_NUM; c++) r_ckpt[c][r] <= NON_DEP;
        end
      end else begin
        // Ascending port order: the youngest writer to a register lands last.
        for (int p = 0; p < COMMIT_PORTS; p++)
          if (w_cvalid[p]) r_regs[w_creg[p]] <= w_cdata[p];
        for (int r = 0; r < REG_SIZE; r++) begin
          r_dep[r] <= w_dep_next[r];
          for (int c = 0; c < CKPT_NUM; c++)
            r_ckpt[c][r] <= (!recover_en && ckpt_en && (ckpt_id == CKPT_WIDTH'(c)))
                            ? w_dep_next[r] : w_ckpt_clr[c][r];
        end
      end
    end
  end

  // Query: a same-cycle commit of the named producer bypasses its data.
  always_comb begin
    w_rs[0] = rs1;
    w_rs[1] = rs2;
    for (int q = 0; q < 2; q++) begin
      w_q[q] = r_dep[w_rs[q]];
      w_v[q] = r_regs[w_rs[q]];
      for (int p = 0; p < COMMIT_PORTS; p++) begin
        if (commit_en[p] && (w_creg[p] == w_rs[q]) &&
            ({1'b0, w_cidx[p]} == r_dep[w_rs[q]])) begin
          w_q[q] = NON_DEP;
          w_v[q] = w_cdata[p];
        end
      end
      if ((w_rs[q] == '0) || flush_signal || recover_en) begin
        w_q[q] = NON_DEP;
        w_v[q] = r_regs[w_rs[q]];
      end else if (w_q[q] != NON_DEP) begin
        w_v[q] = '0;
      end
    end
  end

  assign Qj = w_q[0];
  assign Vj = w_v[0];
  assign Qk = w_q[1];
  assign Vk = w_v[1];

endmodule

// File: tb/tb_rf_rename_ckpt.sv
module tb_rf_rename_ckpt;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_signal;
  logic [1:0]  commit_en;
  logic [9:0]  commit_reg;
  logic [5:0]  commit_index;
  logic [63:0] commit_data;
  logic [4:0]  rs1, rs2, occupied_rd;
  logic [3:0]  Qj, Qk;
  logic [31:0] Vj, Vk;
  logic        new_entry_en, ckpt_en, recover_en;
  logic [2:0]  new_entry_robEntry;
  logic [1:0]  ckpt_id, recover_id;

  always #5 clk_in = ~clk_in;

  rf_rename_ckpt dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_index(commit_index),
    .commit_data(commit_data), .rs1(rs1), .rs2(rs2), .Qj(Qj), .Qk(Qk), .Vj(Vj), .Vk(Vk),
    .new_entry_en(new_entry_en), .new_entry_robEntry(new_entry_robEntry),
    .occupied_rd(occupied_rd), .ckpt_en(ckpt_en), .ckpt_id(ckpt_id),
    .recover_en(recover_en), .recover_id(recover_id)
  );

  typedef struct {
    logic             rst, rdy, fl, ne, cke, rec, chk;
    logic [1:0]       ce;
    logic [1:0][4:0]  cr;
    logic [1:0][2:0]  ci;
    logic [1:0][31:0] cd;
    logic [4:0]       rs1, rs2, rd;
    logic [2:0]       rob;
    logic [1:0]       ckid, recid;
    logic [3:0]       eqj, eqk;
    logic [31:0]      evj, evk;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference state: -1 means "no pending producer".
  logic [31:0] m_regs [32];
  int          m_dep  [32];
  int          m_ck   [4][32];
  vec_t        cur;
  vec_t        tbl [$];

  function automatic vec_t dflt();
    vec_t v;
    v.rst = 0; v.rdy = 1; v.fl = 0; v.ne = 0; v.cke = 0; v.rec = 0; v.chk = 1;
    v.ce = '0; v.cr = '0; v.ci = '0; v.cd = '0;
    v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.rob = 0; v.ckid = 0; v.recid = 0;
    v.eqj = 4'd8; v.eqk = 4'd8; v.evj = 0; v.evk = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cur = v;
    rst_in = v.rst; rdy_in = v.rdy; flush_signal = v.fl;
    commit_en = v.ce; commit_reg = v.cr; commit_index = v.ci; commit_data = v.cd;
    rs1 = v.rs1; rs2 = v.rs2;
    new_entry_en = v.ne; new_entry_robEntry = v.rob; occupied_rd = v.rd;
    ckpt_en = v.cke; ckpt_id = v.ckid; recover_en = v.rec; recover_id = v.recid;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic void m_query(input int rs, output logic [31:0] q, output logic [31:0] val);
    if (rs == 0 || cur.fl || cur.rec) begin
      q = 8; val = m_regs[rs];
      return;
    end
    if (m_dep[rs] < 0) begin q = 8; val = m_regs[rs]; end
    else begin q = m_dep[rs]; val = 0; end
    for (int p = 0; p < 2; p++)
      if (cur.ce[p] && int'(cur.cr[p]) == rs && m_dep[rs] >= 0 && int'(cur.ci[p]) == m_dep[rs]) begin
        q = 8; val = cur.cd[p];
      end
  endfunction

  function automatic void m_step();
    if (cur.rst) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = 0; m_dep[r] = -1;
        for (int c = 0; c < 4; c++) m_ck[c][r] = -1;
      end
      return;
    end
    if (!cur.rdy) return;
    if (cur.fl) begin
      for (int r = 0; r < 32; r++) begin
        m_dep[r] = -1;
        for (int c = 0; c < 4; c++) m_ck[c][r] = -1;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if (cur.ce[p] && cur.cr[p] != 0) begin
        int r = int'(cur.cr[p]);
        if (m_dep[r] == int'(cur.ci[p])) m_dep[r] = -1;
        for (int c = 0; c < 4; c++) if (m_ck[c][r] == int'(cur.ci[p])) m_ck[c][r] = -1;
        m_regs[r] = cur.cd[p];
      end
    end
    if (cur.rec) begin
      for (int r = 0; r < 32; r++) m_dep[r] = m_ck[cur.recid][r];
    end else begin
      if (cur.ne && cur.rd != 0) m_dep[cur.rd] = int'(cur.rob);
      if (cur.cke) for (int r = 0; r < 32; r++) m_ck[cur.ckid][r] = m_dep[r];
    end
  endfunction

  initial begin
    vec_t v;
    logic [31:0] q, val;

    // Directed sequence; expectations are the combinational outputs seen
    // during that cycle, before its clock edge.
    v = dflt(); v.rst = 1; v.chk = 0; tbl.push_back(v);
    v = dflt(); v.rs1 = 5; tbl.push_back(v);
    v = dflt(); v.ne = 1; v.rd = 3; v.rob = 2; v.rs1 = 3; tbl.push_back(v);
    v = dflt(); v.rs1 = 3; v.eqj = 2; tbl.push_back(v);
    v = dflt(); v.ce = 2'b01; v.cr[0] = 3; v.ci[0] = 2; v.cd[0] = 32'hAB; v.rs1 = 3; v.evj = 32'hAB; tbl.push_back(v);
    v = dflt(); v.rs1 = 3; v.rs2 = 3; v.evj = 32'hAB; v.evk = 32'hAB; tbl.push_back(v);
    v = dflt(); v.ce = 2'b11; v.cr[0] = 4; v.cr[1] = 4; v.cd[0] = 32'h11; v.cd[1] = 32'h22; v.rs1 = 4; tbl.push_back(v);
    v = dflt(); v.rs1 = 4; v.evj = 32'h22; tbl.push_back(v);
    v = dflt(); v.ne = 1; v.rd = 6; v.rob = 1; v.cke = 1; v.ckid = 1; v.rs1 = 6; tbl.push_back(v);
    v = dflt(); v.ne = 1; v.rd = 6; v.rob = 4; v.rs1 = 6; v.eqj = 1; tbl.push_back(v);
    v = dflt(); v.rs1 = 6; v.eqj = 4; tbl.push_back(v);
    v = dflt(); v.rec = 1; v.recid = 1; v.rs1 = 6; tbl.push_back(v);
    v = dflt(); v.rs1 = 6; v.eqj = 1; tbl.push_back(v);
    v = dflt(); v.ne = 1; v.rd = 7; v.rob = 5; v.cke = 1; v.ckid = 0; v.rs1 = 7; tbl.push_back(v);
    v = dflt(); v.ce = 2'b01; v.cr[0] = 7; v.ci[0] = 5; v.cd[0] = 32'h77; v.rs1 = 7; v.evj = 32'h77; tbl.push_back(v);
    v = dflt(); v.rec = 1; v.recid = 0; v.rs1 = 7; v.evj = 32'h77; tbl.push_back(v);
    v = dflt(); v.rs1 = 7; v.evj = 32'h77; v.rs2 = 6; v.eqk = 1; tbl.push_back(v);
    v = dflt(); v.ne = 1; v.rd = 9; v.rob = 3; v.rs1 = 6; v.eqj = 1; tbl.push_back(v);
    v = dflt(); v.fl = 1; v.ce = 2'b01; v.cr[0] = 10; v.cd[0] = 32'h55; v.ne = 1; v.rd = 11; v.rob = 2;
      v.cke = 1; v.ckid = 2; v.rs1 = 9; v.rs2 = 10; tbl.push_back(v);
    v = dflt(); v.rs1 = 9; v.rs2 = 6; tbl.push_back(v);
    v = dflt(); v.rs1 = 10; v.rs2 = 11; tbl.push_back(v);
    v = dflt(); v.rdy = 0; v.ne = 1; v.rd = 12; v.rob = 6; v.ce = 2'b01; v.cr[0] = 12; v.cd[0] = 32'h99;
      v.rs1 = 12; v.rs2 = 3; v.evk = 32'hAB; tbl.push_back(v);
    v = dflt(); v.rs1 = 12; v.rs2 = 4; v.evk = 32'h22; tbl.push_back(v);
    v = dflt(); v.rec = 1; v.recid = 1; tbl.push_back(v);
    v = dflt(); v.rs1 = 6; v.rs2 = 9; tbl.push_back(v);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk_in);
      if (tbl[i].chk) begin
        chk("dir_Qj", i, 32'(Qj), 32'(tbl[i].eqj));
        chk("dir_Vj", i, Vj, tbl[i].evj);
        chk("dir_Qk", i, 32'(Qk), 32'(tbl[i].eqk));
        chk("dir_Vk", i, Vk, tbl[i].evk);
      end
      @(posedge clk_in);
      m_step();
      #1;
    end

    // Random traffic over a narrow register window so claims, commits,
    // checkpoints and recoveries collide often.
    for (int n = 0; n < 3000; n++) begin
      v = dflt();
      v.rst   = ($urandom_range(0, 199) == 0);
      v.rdy   = ($urandom_range(0, 7) != 0);
      v.fl    = ($urandom_range(0, 39) == 0);
      v.rec   = ($urandom_range(0, 11) == 0);
      v.recid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        v.ce[p] = 1'($urandom_range(0, 1));
        v.cr[p] = 5'($urandom_range(0, 7));
        if (m_dep[v.cr[p]] >= 0 && $urandom_range(0, 3) != 0) v.ci[p] = 3'(m_dep[v.cr[p]]);
        else v.ci[p] = 3'($urandom_range(0, 7));
        v.cd[p] = $urandom;
      end
      v.ne   = 1'($urandom_range(0, 1));
      v.rd   = 5'($urandom_range(0, 7));
      v.rob  = 3'($urandom_range(0, 7));
      v.cke  = ($urandom_range(0, 3) == 0);
      v.ckid = 2'($urandom_range(0, 3));
      v.rs1  = 5'($urandom_range(0, 7));
      v.rs2  = 5'($urandom_range(0, 7));
      drive(v);
      @(negedge clk_in);
      m_query(int'(v.rs1), q, val);
      chk("rnd_Qj", n, 32'(Qj), q);
      chk("rnd_Vj", n, Vj, val);
      m_query(int'(v.rs2), q, val);
      chk("rnd_Qk", n, 32'(Qk), q);
      chk("rnd_Vk", n, Vk, val);
      @(posedge clk_in);
      m_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
